// File: rtl/ahb_req_arbiter.sv
// ahb_req_arbiter: two-requester round-robin AHB-Lite master front end.
// Wait-state timeout is built only when AHB_ARB_TIMEOUT_EN is defined.
module ahb_req_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              Hclk,
   input  logic              Hresetn,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic              req0_write,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   input  logic [2:0]        req0_size,
   output logic              rsp0_valid,
   output logic [DATA_W-1:0] rsp0_rdata,
   output logic              rsp0_err,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic              req1_write,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   input  logic [2:0]        req1_size,
   output logic              rsp1_valid,
   output logic [DATA_W-1:0] rsp1_rdata,
   output logic              rsp1_err,
   output logic [1:0]        grant,
   output logic [1:0]        Htrans,
   output logic [ADDR_W-1:0] Haddr,
   output logic              Hwrite,
   output logic [DATA_W-1:0] Hwdata,
   output logic [2:0]        Hsize,
   output logic [2:0]        Hburst,
   output logic              Hreadyin,
   input  logic              Hreadyout,
   input  logic [DATA_W-1:0] Hrdata,
   input  logic [1:0]        Hresp
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_RESP
   } state_t;

   state_t                   r_state;
   logic                     r_last;
   logic [1:0]               r_grant;
   logic [1:0]               r_htrans;
   logic [ADDR_W-1:0]        r_haddr;
   logic                     r_hwrite;
   logic [DATA_W-1:0]        r_hwdata;
   logic [2:0]               r_hsize;
   logic [1:0]               r_rsp_valid;
   logic [1:0][DATA_W-1:0]   r_rdata;
   logic [1:0]               r_err;

   logic                     w_idle;
   logic                     w_win0;
   logic                     w_win1;
   logic                     w_go;
   logic                     w_sel;
   logic                     w_own;
   logic                     w_write;
   logic [ADDR_W-1:0]        w_addr;
   logic [DATA_W-1:0]        w_wdata;
   logic [2:0]               w_size;

`ifdef AHB_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0]            r_wait;
   logic                     w_tmo;
   assign w_tmo = (r_wait == TW'(TIMEOUT_CYC - 1));
`else
   localparam int unused_tmo = TIMEOUT_CYC;
`endif

   // r_last = 1 means req1 was served last, so req0 wins a tie
   assign w_win0  = req0_valid & (~req1_valid | r_last);
   assign w_win1  = req1_valid & (~req0_valid | ~r_last);
   assign w_idle  = (r_state == S_IDLE) & Hresetn;
   assign w_go    = w_idle & (w_win0 | w_win1);
   assign w_sel   = w_win1;
   assign w_own   = r_grant[1];

   assign req0_ready = w_idle & w_win0;
   assign req1_ready = w_idle & w_win1;

   assign w_write = w_sel ? req1_write : req0_write;
   assign w_addr  = w_sel ? req1_addr  : req0_addr;
   assign w_wdata = w_sel ? req1_wdata : req0_wdata;
   assign w_size  = w_sel ? req1_size  : req0_size;

   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         r_state     <= S_IDLE;
         r_last      <= 1'b1;
         r_grant     <= 2'b00;
         r_htrans    <= 2'b00;
         r_haddr     <= '0;
         r_hwrite    <= 1'b0;
         r_hwdata    <= '0;
         r_hsize     <= 3'b010;
         r_rsp_valid <= 2'b00;
         r_rdata     <= '0;
         r_err       <= 2'b00;
`ifdef AHB_ARB_TIMEOUT_EN
         r_wait      <= '0;
`endif
      end else begin
         r_rsp_valid <= 2'b00;
         unique case (r_state)
            S_IDLE: begin
               if (w_go) begin
                  r_grant <= w_sel ? 2'b10 : 2'b01;
                  if (w_size > 3'b010) begin
                     r_rsp_valid[w_sel] <= 1'b1;
                     r_rdata[w_sel]     <= '0;
                     r_err[w_sel]       <= 1'b1;
                     r_state            <= S_RESP;
                  end else begin
                     r_htrans <= 2'b10;
                     r_haddr  <= w_addr;
                     r_hwrite <= w_write;
                     r_hwdata <= w_wdata;
                     r_hsize  <= w_size;
                     r_state  <= S_ADDR;
`ifdef AHB_ARB_TIMEOUT_EN
                     r_wait   <= '0;
`endif
                  end
               end
            end
            S_ADDR: begin
               if (Hreadyout) begin
                  r_htrans <= 2'b00;
                  r_state  <= S_DATA;
`ifdef AHB_ARB_TIMEOUT_EN
                  r_wait   <= '0;
               end else if (w_tmo) begin
                  r_htrans           <= 2'b00;
                  r_rsp_valid[w_own] <= 1'b1;
                  r_rdata[w_own]     <= '0;
                  r_err[w_own]       <= 1'b1;
                  r_state            <= S_RESP;
               end else begin
                  r_wait <= r_wait + 1'b1;
`endif
               end
            end
            S_DATA: begin
               if (Hreadyout) begin
                  r_rsp_valid[w_own] <= 1'b1;
                  r_rdata[w_own]     <= r_hwrite ? '0 : Hrdata;
                  r_err[w_own]       <= (Hresp != 2'b00);
                  r_state            <= S_RESP;
`ifdef AHB_ARB_TIMEOUT_EN
               end else if (w_tmo) begin
                  r_rsp_valid[w_own] <= 1'b1;
                  r_rdata[w_own]     <= '0;
                  r_err[w_own]       <= 1'b1;
                  r_state            <= S_RESP;
               end else begin
                  r_wait <= r_wait + 1'b1;
`endif
               end
            end
            S_RESP: begin
               r_last  <= w_own;
               r_grant <= 2'b00;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign grant      = r_grant;
   assign Htrans     = r_htrans;
   assign Haddr      = r_haddr;
   assign Hwrite     = r_hwrite;
   assign Hwdata     = r_hwdata;
   assign Hsize      = r_hsize;
   assign Hburst     = 3'b000;
   assign Hreadyin   = 1'b1;
   assign rsp0_valid = r_rsp_valid[0];
   assign rsp1_valid = r_rsp_valid[1];
   assign rsp0_rdata = r_rdata[0];
   assign rsp1_rdata = r_rdata[1];
   assign rsp0_err   = r_err[0];
   assign rsp1_err   = r_err[1];

endmodule
